// File: rtl/stream_demux_pkg.sv
// Shared types for the four-way stream demultiplexer: holding-register state and selector width.
package stream_demux_pkg;
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/xfer_counter.sv
// Wrapping transfer counter: +1 on each cycle inc is high, zero on async reset.
// Latency: the count reflects an increment from the edge that sampled inc; never stalls.
module xfer_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/stream_demux4.sv
// One-entry demux: steers each input word to output in_sel, with per-output transfer counters.
// Latency: word visible on its output the cycle after acceptance; in_ready follows the selected out_ready.
module stream_demux4
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [1:0]               in_sel,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_OUT*CNT_W-1:0] cnt_flat
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  sel_t              sel_q, sel_d;

  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    sel_d     = sel_q;
    in_ready  = 1'b1;
    out_valid = '0;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          state_d = FULL;
          data_d  = in_data;
          sel_d   = in_sel;
        end
      end
      FULL: begin
        out_valid = NUM_OUT'(1) << sel_q;
        in_ready  = out_ready[sel_q];
        if (out_ready[sel_q]) begin
          if (in_valid) begin
            data_d = in_data;
            sel_d  = in_sel;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_data = data_q;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_cnt
    xfer_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (out_valid[i] & out_ready[i]),
      .count (cnt_flat[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4: a scoreboard tracks accepted words and per-output counts,
// while a default-width and a 2-bit-counter instance share the same stimulus.
module tb_stream_demux4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;
  logic        in_ready,  in_ready_n;
  logic [3:0]  out_valid, out_valid_n;
  logic [7:0]  out_data,  out_data_n;
  logic [31:0] cnt_flat;
  logic [7:0]  cnt_flat_n;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt[4];

  always #5 clk = ~clk;

  stream_demux4 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .cnt_flat(cnt_flat)
  );

  stream_demux4 #(.DATA_W(8), .CNT_W(2)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_data(out_data_n), .cnt_flat(cnt_flat_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: expected handshake behaviour derives from the queued words only.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    end else begin
      logic [3:0] exp_ov;
      logic       exp_rdy;
      exp_t       e;
      exp_ov  = 4'b0000;
      exp_rdy = 1'b1;
      if (exp_q.size() != 0) begin
        e       = exp_q[0];
        exp_ov  = 4'b0001 << e.sel;
        exp_rdy = out_ready[e.sel];
      end
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("cnt%0d", i), 32'(cnt_flat[i*8 +: 8]), 32'(model_cnt[i] % 256));
        chk($sformatf("cnt%0d_narrow", i), 32'(cnt_flat_n[i*2 +: 2]), 32'(model_cnt[i] % 4));
      end
      chk("mon_out_valid", 32'(out_valid), 32'(exp_ov));
      chk("mon_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (exp_q.size() != 0) chk("mon_out_data", 32'(out_data), 32'(e.data));
      if ((exp_ov & out_ready) != 4'b0000) begin
        void'(exp_q.pop_front());
        model_cnt[e.sel]++;
      end
      if (in_valid && exp_rdy) exp_q.push_back('{data: in_data, sel: in_sel});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sels[5];
    logic [1:0] wrap_seq[5];
    sels     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    out_ready = 4'b0000;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_cnt_flat", cnt_flat, 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    step();
    rst_n = 1'b1;

    // Single word held under backpressure, then released.
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("single_out_valid", 32'(out_valid), 32'h4);
      chk("single_out_data", 32'(out_data), 32'hA5);
      chk("single_in_ready", 32'(in_ready), 32'h0);
      step();
    end
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    chk("single_cnt2", 32'(cnt_flat[23:16]), 32'h1);
    chk("single_empty_valid", 32'(out_valid), 32'h0);
    chk("single_empty_ready", 32'(in_ready), 32'h1);
    chk("single_hold_data", 32'(out_data), 32'hA5);

    // Back-to-back streaming across all outputs.
    do_reset();
    out_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + k); in_sel = sels[k];
      chk("b2b_in_ready", 32'(in_ready), 32'h1);
      step();
      chk("b2b_out_valid", 32'(out_valid), 32'(4'b0001 << sels[k]));
      chk("b2b_out_data", 32'(out_data), 32'(8'h10 + k));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_counts", cnt_flat, 32'h01010102);
    chk("b2b_counts_narrow", 32'(cnt_flat_n), 32'h56);

    // Backpressure on output 1 while other consumers are ready.
    do_reset();
    out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 8'h3C; in_sel = 2'd1;
    step();
    in_data = 8'h77; in_sel = 2'd0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 32'(out_valid), 32'h2);
      chk("bp_out_data", 32'(out_data), 32'h3C);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_cnt", cnt_flat, 32'h0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 4'b0010;
    step();
    chk("bp_cnt1", cnt_flat, 32'h00000100);
    chk("bp_drained", 32'(out_valid), 32'h0);

    // Counter wrap on the 2-bit instance, output 3.
    do_reset();
    out_ready = 4'b1000;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hC0;
    step();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) in_valid = 1'b0;
      in_data = 8'(8'hC1 + k);
      step();
      chk("wrap_cnt3", 32'(cnt_flat_n[7:6]), 32'(wrap_seq[k]));
    end
    chk("wrap_cnt3_wide", 32'(cnt_flat[31:24]), 32'h5);

    // Reset while a word for output 0 is held.
    do_reset();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    chk("mrst_full", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'h0);
    chk("mrst_in_ready", 32'(in_ready), 32'h1);
    chk("mrst_out_data", 32'(out_data), 32'h0);
    out_ready = 4'b1111;
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h66;
    step();
    in_valid = 1'b0;
    chk("mrst_cnt0", 32'(cnt_flat[7:0]), 32'h0);
    chk("post_rst_accept", 32'(out_valid), 32'h2);
    chk("post_rst_data", 32'(out_data), 32'h66);
    step();
    step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("final_counts", cnt_flat, 32'h00000100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits.
REQ-002 Parameter CNT_W, default 8: width of each per-output transfer counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1: upstream word present.
REQ-006 Port in_ready, output, 1: block accepts a word this cycle.
REQ-007 Port in_data, input, DATA_W: upstream payload.
REQ-008 Port in_sel, input, 2: destination index, 0..3, sampled with in_data.
REQ-009 Port out_valid, output, 4: bit i set means output i holds a word.
REQ-010 Port out_ready, input, 4: bit i set means consumer i accepts.
REQ-011 Port out_data, output, DATA_W: payload, shared by all four outputs.
REQ-012 Port cnt_flat, output, 4*CNT_W: completed-transfer counters; slice i is output i.

Function
REQ-013 Input handshake: a transfer occurs when in_valid and in_ready are both high on a rising edge.
REQ-014 Output handshake: a transfer on output i occurs when out_valid[i] and out_ready[i] are both high on a rising edge.
REQ-015 The block has one holding register, with data_q, sel_q and a two-state FSM: EMPTY and FULL.
REQ-016 In EMPTY: in_ready=1 and out_valid=0000.
REQ-017 EMPTY -> FULL on an input transfer; data_q and sel_q load in_data and in_sel.
REQ-018 In FULL: out_valid is one-hot at bit sel_q; out_data=data_q; the other out_valid bits are 0.
REQ-019 In FULL: in_ready=out_ready[sel_q]; there is no combinational path from in_valid to in_ready.
REQ-020 FULL with an output transfer and no input transfer -> EMPTY.
REQ-021 FULL with an output transfer and an input transfer in the same cycle -> stays FULL and reloads data_q/sel_q; this sustains 1 word per cycle.
REQ-022 FULL without an output transfer -> holds; data_q, sel_q and out_valid stay stable (no retraction).
REQ-023 Latency: a word accepted at edge N is presented on its output from edge N onward, i.e. visible in cycle N+1.
REQ-024 out_ready[j] for j != sel_q has no effect.
REQ-025 Counter i increments by 1 on each output-i transfer and wraps from 2^CNT_W-1 to 0.
REQ-026 Word ordering is preserved across all outputs, because there is a single entry.
REQ-027 out_data is don't-care in EMPTY but SHALL hold its last value, with no X after reset.

Reset
REQ-028 When rst_n is low, asynchronously: state=EMPTY, data_q=0, sel_q=0, all counters=0, out_valid=0000, in_ready=1 as a combinational result of EMPTY.
REQ-029 Reset asserted mid-transfer discards the held word; no output transfer is reported for it.
REQ-030 After rst_n deasserts, the first edge accepts input normally.

Structure
REQ-031 A shared package stream_demux_pkg holds the state enum (EMPTY, FULL), the constant NUM_OUT=4 and the SEL_W=2 typedef.
REQ-032 A single sub-module xfer_counter (parameter CNT_W; inputs clk, rst_n, inc; output count) is instantiated four times.
REQ-033 The FSM and holding register live in the top module; no other hierarchy.

Verification
REQ-034 Reset: rst_n low -> out_valid=0000, in_ready=1, cnt_flat=0, out_data=0.
REQ-035 Single word: in_data=8'hA5, in_sel=2, out_ready=0000 -> out_valid=0100, out_data=A5, in_ready=0; then out_ready=0100 -> one transfer, cnt2=1, state EMPTY.
REQ-036 Back-to-back: all out_ready=1, in_valid=1 with sel sequence 0,1,2,3,0 -> one output transfer per cycle; final counts 2,1,1,1.
REQ-037 Backpressure: sel=1 held with out_ready[1]=0 and out_ready[0,2,3]=1 for 5 cycles -> out_valid=0010 and data stable; no counter changes; in_ready=0.
REQ-038 Wrap: CNT_W=2, 5 transfers to output 3 -> cnt3 sequence 1,2,3,0,1.
REQ-039 Mid-operation reset: FULL with sel=0, assert rst_n low for 1 cycle -> out_valid=0000 immediately, cnt0 unchanged at 0, word lost.
